hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 19 +
 rtl/hazard_scoreboard_fwd_mux_sel.sv | 27 ++
 rtl/hazard_scoreboard.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the execute-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int REG_AW_DEF = 5;

    // Forward-select encoding: 0 = register file, k+1 = stage k.
    localparam int FWD_SEL_RF = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FENCE = 2'd2
    } hs_state_e;

    function automatic int fwd_sel_stage(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_mux_sel.sv
// Priority match of one source register against all forwarding stages.
module fwd_mux_sel
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int FWD_W      = 2
) (
    input  logic                         en,
    input  logic [REG_AW-1:0]            rs,
    input  logic [NUM_STAGES-1:0]        stg_reg_wr,
    input  logic [NUM_STAGES*REG_AW-1:0] stg_rd,
    output logic [FWD_W-1:0]             sel
);

    // Walk from the oldest stage down so the youngest match wins.
    always_comb begin
        sel = FWD_W'(FWD_SEL_RF);
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (en && (rs != '0) && stg_reg_wr[k] &&
                (stg_rd[k*REG_AW +: REG_AW] == rs)) begin
                sel = FWD_W'(fwd_sel_stage(k));
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Execute-stage hazard unit: forwarding select, load-use and long-op
// scoreboard stalls, branch flush and fence sequencing.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int NUM_FWD_STAGES = 2,
    parameter  int REG_AW         = REG_AW_DEF,
    parameter  int MAX_PENDING    = 4,
    parameter  int FLUSH_CYCLES   = 1,
    localparam int FWD_W          = $clog2(NUM_FWD_STAGES + 1),
    localparam int CNT_W          = $clog2(MAX_PENDING + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REG_AW-1:0]                ex_rs1,
    input  logic [REG_AW-1:0]                ex_rs2,
    input  logic [1:0]                       ex_rs_use,
    input  logic [NUM_FWD_STAGES-1:0]        stg_reg_wr,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_rd,
    input  logic                             stg0_mem_read,
    input  logic                             long_issue,
    input  logic [REG_AW-1:0]                long_rd,
    input  logic                             long_done,
    input  logic [REG_AW-1:0]                long_done_rd,
    input  logic                             fence_req,
    input  logic                             br_taken,
    output logic [FWD_W-1:0]                 fwd_sel_1,
    output logic [FWD_W-1:0]                 fwd_sel_2,
    output logic                             stall,
    output logic                             flush,
    output logic [CNT_W-1:0]                 pending_cnt,
    output logic                             sb_overflow
);

    localparam int            NUM_REGS  = 2 ** REG_AW;
    localparam logic [2:0]    FC_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    hs_state_e             state_q, state_d;
    logic [2:0]            fcnt_q, fcnt_d;
    logic [NUM_REGS-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    logic [1:0]            use_eff;
    logic                  used1, used2;
    logic [REG_AW-1:0]     rd0;
    logic                  load_use, sb_hit, waw, full;
    logic                  fence_wait, flush_raw, stall_raw;
    logic                  issue_acc, done_vld;

    fwd_mux_sel #(
        .NUM_STAGES (NUM_FWD_STAGES),
        .REG_AW     (REG_AW),
        .FWD_W      (FWD_W)
    ) u_fwd1 (
        .en         (rst_n),
        .rs         (ex_rs1),
        .stg_reg_wr (stg_reg_wr),
        .stg_rd     (stg_rd),
        .sel        (fwd_sel_1)
    );

    fwd_mux_sel #(
        .NUM_STAGES (NUM_FWD_STAGES),
        .REG_AW     (REG_AW),
        .FWD_W      (FWD_W)
    ) u_fwd2 (
        .en         (rst_n),
        .rs         (ex_rs2),
        .stg_reg_wr (stg_reg_wr),
        .stg_rd     (stg_rd),
        .sel        (fwd_sel_2)
    );

    // Sources count as unused while reset is held.
    assign use_eff = rst_n ? ex_rs_use : 2'b00;
    assign used1   = use_eff[0] && (ex_rs1 != '0);
    assign used2   = use_eff[1] && (ex_rs2 != '0);
    assign rd0     = stg_rd[REG_AW-1:0];

    assign load_use = stg0_mem_read && stg_reg_wr[0] && (rd0 != '0) &&
                      ((used1 && (rd0 == ex_rs1)) ||
                       (used2 && (rd0 == ex_rs2)));
    assign sb_hit   = (used1 && pend_q[ex_rs1]) ||
                      (used2 && pend_q[ex_rs2]);
    assign waw      = long_issue && (long_rd != '0) && pend_q[long_rd];
    assign full     = long_issue && (long_rd != '0) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        fence_wait = 1'b0;
        flush_raw  = br_taken || (state_q == ST_FLUSH);
        unique case (state_q)
            ST_RUN: begin
                fence_wait = fence_req && (cnt_q != '0);
                if (br_taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FC_RELOAD;
                    end
                end else if (fence_wait) begin
                    state_d = ST_FENCE;
                end
            end
            ST_FLUSH: begin
                if (br_taken) begin
                    fcnt_d = FC_RELOAD;
                end else if (fcnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            ST_FENCE: begin
                fence_wait = (cnt_q != '0);
                if (br_taken) begin
                    fcnt_d = 3'd0;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FC_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    assign stall_raw = !flush_raw &&
                       (load_use || sb_hit || waw || full || fence_wait);
    assign stall     = rst_n && stall_raw;
    assign flush     = rst_n && flush_raw;

    assign issue_acc = long_issue && (long_rd != '0) && !stall_raw && !flush_raw;
    assign done_vld  = long_done && (long_done_rd != '0) && pend_q[long_done_rd];

    // Clear before set so a same-register done+issue leaves the bit set.
    always_comb begin
        pend_d = pend_q;
        if (done_vld) pend_d[long_done_rd] = 1'b0;
        if (issue_acc) pend_d[long_rd] = 1'b1;
        cnt_d = cnt_q;
        if (issue_acc && !done_vld) cnt_d = cnt_q + CNT_W'(1);
        if (done_vld && !issue_acc) cnt_d = cnt_q - CNT_W'(1);
        ovf_d = ovf_q ||
                (issue_acc && !done_vld && (cnt_q == CNT_MAX)) ||
                (done_vld && !issue_acc && (cnt_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= 3'd0;
            pend_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pending_cnt = cnt_q;
    assign sb_overflow = ovf_q;

endmodule
